// File: rtl/tx_rs232_cfg_if.sv
// Core-side bundle of the configurable RS-232 transmitter.
// The core drives the master side. The transmitter uses the slave side.
interface tx_rs232_cfg_if #(
   parameter int DATA_W = 8
) ();
   logic              iSEND;
   logic [DATA_W-1:0] iDATA;
   logic              oREADY;
   logic              oDATA;
   logic              oBUSY;
   logic              oFINISH;
   logic              oOVERRUN;

   modport master (
      output iSEND, iDATA,
      input  oREADY, oDATA, oBUSY, oFINISH, oOVERRUN
   );

   modport slave (
      input  iSEND, iDATA,
      output oREADY, oDATA, oBUSY, oFINISH, oOVERRUN
   );
endinterface

// File: rtl/tx_rs232_cfg.sv
// Configurable RS-232 transmitter with an input FIFO. Words are sent LSB first.
// The frame is start bit, data bits, optional parity bit, then 1 or 2 stop bits.
module tx_rs232_cfg #(
   parameter int CLK_DIV    = 434,
   parameter int DATA_W     = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic            clk_s,
   input  logic            rstn_s,
   tx_rs232_cfg_if.slave   bus
);

   localparam int BAUD_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP
   } state_t;

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_d;
   logic              push;
   logic              pop;

   state_t            state_q;
   logic [BAUD_W-1:0] baud_q;
   logic [3:0]        bit_q;
   logic [DATA_W-1:0] shift_q;
   logic              parity_q;
   logic              frame_done_q;
   logic              baud_end;
   logic              line_d;

   logic              ready_q;
   logic              data_q;
   logic              busy_q;
   logic              finish_q;
   logic              overrun_q;

   // ready_q mirrors (count_q != FIFO_DEPTH), so a full FIFO never takes a push
   assign push     = bus.iSEND && ready_q;
   assign pop      = (state_q == S_IDLE) && (count_q != '0);
   assign baud_end = (baud_q == BAUD_W'(CLK_DIV - 1));

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_s) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.iDATA;
      end
   end

   always_ff @(posedge clk_s or negedge rstn_s) begin
      if (!rstn_s) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ready_q   <= 1'b1;
         overrun_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q   <= count_d;
         ready_q   <= (count_d != CNT_W'(FIFO_DEPTH));
         overrun_q <= bus.iSEND && !ready_q;
      end
   end

   always_comb begin
      line_d = 1'b1;
      unique case (state_q)
         S_START: line_d = 1'b0;
         S_DATA:  line_d = shift_q[0];
         S_PAR:   line_d = parity_q;
         default: line_d = 1'b1;
      endcase
   end

   // The line, busy and finish outputs trail the state by one cycle.
   // This keeps oFINISH aligned with the end of the last stop bit on oDATA.
   always_ff @(posedge clk_s or negedge rstn_s) begin
      if (!rstn_s) begin
         state_q      <= S_IDLE;
         baud_q       <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         parity_q     <= 1'b0;
         frame_done_q <= 1'b0;
         data_q       <= 1'b1;
         busy_q       <= 1'b0;
         finish_q     <= 1'b0;
      end else begin
         data_q       <= line_d;
         busy_q       <= (state_q != S_IDLE) || (count_q != '0);
         finish_q     <= frame_done_q;
         frame_done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               baud_q <= '0;
               bit_q  <= '0;
               if (pop) begin
                  shift_q  <= mem_q[rd_ptr_q];
                  parity_q <= (PARITY == 1) ? ~^mem_q[rd_ptr_q] : ^mem_q[rd_ptr_q];
                  state_q  <= S_START;
               end
            end
            S_START: begin
               if (baud_end) begin
                  baud_q  <= '0;
                  state_q <= S_DATA;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            S_DATA: begin
               if (baud_end) begin
                  baud_q  <= '0;
                  shift_q <= shift_q >> 1;
                  if (bit_q == 4'(DATA_W - 1)) begin
                     bit_q   <= '0;
                     state_q <= (PARITY != 0) ? S_PAR : S_STOP;
                  end else begin
                     bit_q <= bit_q + 1'b1;
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            S_PAR: begin
               if (baud_end) begin
                  baud_q  <= '0;
                  state_q <= S_STOP;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            S_STOP: begin
               if (baud_end) begin
                  baud_q <= '0;
                  if (bit_q == 4'(STOP_BITS - 1)) begin
                     bit_q        <= '0;
                     state_q      <= S_IDLE;
                     frame_done_q <= 1'b1;
                  end else begin
                     bit_q <= bit_q + 1'b1;
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.oREADY   = ready_q;
   assign bus.oDATA    = data_q;
   assign bus.oBUSY    = busy_q;
   assign bus.oFINISH  = finish_q;
   assign bus.oOVERRUN = overrun_q;

endmodule

// File: tb/tb_tx_rs232_cfg.sv
// Directed bench for tx_rs232_cfg. Four instances are built with different frame formats.
// A: 8E1, B: 8O1, C: 8N2, D: 5E1. All use CLK_DIV=4 and FIFO_DEPTH=4.
module tb_tx_rs232_cfg;

   logic clk;
   logic rstn;
   int   checks;
   int   errors;

   tx_rs232_cfg_if #(.DATA_W(8)) if_a ();
   tx_rs232_cfg_if #(.DATA_W(8)) if_b ();
   tx_rs232_cfg_if #(.DATA_W(8)) if_c ();
   tx_rs232_cfg_if #(.DATA_W(5)) if_d ();

   tx_rs232_cfg #(.CLK_DIV(4), .DATA_W(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
      dut_a (.clk_s(clk), .rstn_s(rstn), .bus(if_a));
   tx_rs232_cfg #(.CLK_DIV(4), .DATA_W(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
      dut_b (.clk_s(clk), .rstn_s(rstn), .bus(if_b));
   tx_rs232_cfg #(.CLK_DIV(4), .DATA_W(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
      dut_c (.clk_s(clk), .rstn_s(rstn), .bus(if_c));
   tx_rs232_cfg #(.CLK_DIV(4), .DATA_W(5), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
      dut_d (.clk_s(clk), .rstn_s(rstn), .bus(if_d));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic line(input int sel);
      case (sel)
         0:       return if_a.oDATA;
         1:       return if_b.oDATA;
         2:       return if_c.oDATA;
         default: return if_d.oDATA;
      endcase
   endfunction

   function automatic logic fin(input int sel);
      case (sel)
         0:       return if_a.oFINISH;
         1:       return if_b.oFINISH;
         2:       return if_c.oFINISH;
         default: return if_d.oFINISH;
      endcase
   endfunction

   task automatic drive(input int sel, input logic s, input logic [8:0] w);
      case (sel)
         0:       begin if_a.iSEND = s; if_a.iDATA = w[7:0]; end
         1:       begin if_b.iSEND = s; if_b.iDATA = w[7:0]; end
         2:       begin if_c.iSEND = s; if_c.iDATA = w[7:0]; end
         default: begin if_d.iSEND = s; if_d.iDATA = w[4:0]; end
      endcase
   endtask

   task automatic send(input int sel, input logic [8:0] w);
      drive(sel, 1'b1, w);
      tick();
      drive(sel, 1'b0, w);
      $display("send dut%0d word=0x%0h", sel, w);
   endtask

   // Waits for a start bit, then samples every line cycle of one frame.
   // Bit k is taken from the cycles S+4k..S+4k+3 and all four cycles must agree.
   task automatic capture(input int sel, input string tag, input logic [15:0] exp_bits,
                          input int nbits, input int exp_fin, input int exp_wait);
      int          t;
      int          fin_at;
      int          fin_cnt;
      int          glitch;
      logic        cur;
      logic [15:0] bits;
      t = 0;
      while (line(sel) !== 1'b0 && t < 400) begin
         tick();
         t++;
      end
      check({tag, "_start"}, 32'(line(sel)), 32'd0);
      if (exp_wait >= 0) check({tag, "_wait"}, t, exp_wait);
      bits    = '0;
      fin_at  = -1;
      fin_cnt = 0;
      glitch  = 0;
      cur     = 1'b0;
      for (int i = 0; i <= nbits * 4; i++) begin
         if (i < nbits * 4) begin
            if (i % 4 == 0) begin
               cur = line(sel);
               bits[i / 4] = cur;
            end else if (line(sel) !== cur) begin
               glitch++;
            end
         end
         if (fin(sel) === 1'b1) begin
            fin_cnt++;
            if (fin_at < 0) fin_at = i;
         end
         if (i < nbits * 4) tick();
      end
      check({tag, "_bits"}, 32'(bits), 32'(exp_bits));
      check({tag, "_stable"}, glitch, 0);
      check({tag, "_finish_at"}, fin_at, exp_fin);
      check({tag, "_finish_cnt"}, fin_cnt, 1);
      check({tag, "_idle_after"}, 32'(line(sel)), 32'd1);
      $display("frame %s dut%0d bits=0x%0h finish_at=%0d", tag, sel, bits, fin_at);
   endtask

   initial begin
      logic [7:0] words [6];
      logic       exp_rdy [6];
      logic       exp_ovr [6];
      int         zeros;

      checks = 0;
      errors = 0;
      rstn   = 1'b0;
      for (int s = 0; s < 4; s++) drive(s, 1'b0, 9'h0);

      // 1: reset held with iSEND toggling
      for (int k = 0; k < 6; k++) begin
         for (int s = 0; s < 4; s++) drive(s, k[0], 9'h1AB);
         tick();
         check("rst_data", 32'(if_a.oDATA), 32'd1);
         check("rst_busy", 32'(if_a.oBUSY), 32'd0);
         check("rst_finish", 32'(if_a.oFINISH), 32'd0);
         check("rst_overrun", 32'(if_a.oOVERRUN), 32'd0);
         check("rst_ready", 32'(if_a.oREADY), 32'd1);
      end
      for (int s = 0; s < 4; s++) drive(s, 1'b0, 9'h0);
      rstn = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      check("post_rst_data", 32'(if_a.oDATA), 32'd1);
      check("post_rst_busy", 32'(if_a.oBUSY), 32'd0);

      // 2: 8E1 frame of 8'h11 and its latency
      send(0, 9'h011);
      check("lat_n0_data", 32'(if_a.oDATA), 32'd1);
      tick();
      check("lat_n1_data", 32'(if_a.oDATA), 32'd1);
      check("lat_n1_busy", 32'(if_a.oBUSY), 32'd1);
      tick();
      check("lat_n2_data", 32'(if_a.oDATA), 32'd0);
      capture(0, "a_11", 16'h0422, 11, 44, 0);
      check("a_11_busy_end", 32'(if_a.oBUSY), 32'd0);

      // 3: odd parity, then no parity with two stop bits
      send(1, 9'h007);
      capture(1, "b_07", 16'h040E, 11, 44, 2);
      send(2, 9'h0C3);
      capture(2, "c_C3", 16'h0786, 11, 44, 2);

      // 6: five-bit words
      send(3, 9'h01F);
      capture(3, "d_1F", 16'h00FE, 8, 32, 2);

      // 4: burst of six writes. The first is popped at once and the next four fill the FIFO.
      words[0] = 8'h3C; words[1] = 8'hA1; words[2] = 8'hA2;
      words[3] = 8'hA3; words[4] = 8'hA4; words[5] = 8'hA5;
      exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b1; exp_rdy[2] = 1'b1;
      exp_rdy[3] = 1'b1; exp_rdy[4] = 1'b0; exp_rdy[5] = 1'b0;
      exp_ovr[0] = 1'b0; exp_ovr[1] = 1'b0; exp_ovr[2] = 1'b0;
      exp_ovr[3] = 1'b0; exp_ovr[4] = 1'b0; exp_ovr[5] = 1'b1;
      fork
         begin
            for (int k = 0; k < 6; k++) begin
               drive(0, 1'b1, {1'b0, words[k]});
               tick();
               $display("burst write 0x%0h ready=%0b overrun=%0b", words[k], if_a.oREADY, if_a.oOVERRUN);
               check("burst_ready", 32'(if_a.oREADY), 32'(exp_rdy[k]));
               check("burst_overrun", 32'(if_a.oOVERRUN), 32'(exp_ovr[k]));
            end
            drive(0, 1'b0, 9'h0);
            tick();
            check("burst_overrun_clear", 32'(if_a.oOVERRUN), 32'd0);
         end
         begin
            capture(0, "a_3C", 16'h0478, 11, 44, 3);
            capture(0, "a_A1", 16'h0742, 11, 44, 1);
            capture(0, "a_A2", 16'h0744, 11, 44, 1);
            capture(0, "a_A3", 16'h0546, 11, 44, 1);
            capture(0, "a_A4", 16'h0748, 11, 44, 1);
         end
      join
      zeros = 0;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (if_a.oDATA !== 1'b1) zeros++;
      end
      check("burst_no_fifth", zeros, 0);
      check("burst_busy_end", 32'(if_a.oBUSY), 32'd0);

      // 5: reset in the middle of the data bits of 8'h55 while 8'h99 waits in the FIFO
      send(0, 9'h055);
      send(0, 9'h099);
      for (int k = 0; k < 10; k++) tick();
      check("mid_data_bit", 32'(if_a.oDATA), 32'd0);
      rstn = 1'b0;
      #1;
      check("abort_data", 32'(if_a.oDATA), 32'd1);
      check("abort_busy", 32'(if_a.oBUSY), 32'd0);
      check("abort_ready", 32'(if_a.oREADY), 32'd1);
      tick();
      tick();
      rstn = 1'b1;
      zeros = 0;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (if_a.oDATA !== 1'b1) zeros++;
      end
      check("abort_fifo_flushed", zeros, 0);
      check("abort_busy_after", 32'(if_a.oBUSY), 32'd0);
      send(0, 9'h05A);
      capture(0, "a_5A", 16'h04B4, 11, 44, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
